// File: rtl/riscv_dmem_arbiter.sv
// Two-master data-memory arbiter in front of the IO bridge; RISCV_DMEM_ARB_RR_EN selects round-robin ties, else m0 wins ties.
// Latency: write 2 cycles gnt-to-idle, read READ_LAT+2 cycles from gnt to rvalid inclusive.
// Backpressure: one transaction in flight; gnt only while idle, so requesters hold req until granted.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SW  2'b00
`define CACHE_D_WRITE_SH  2'b01
`define CACHE_D_WRITE_SB  2'b10
`endif

module riscv_dmem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_req,
    input  logic                          m1_req,
    input  logic                          m0_we,
    input  logic                          m1_we,
    input  logic [`CACHE_D_WRITE_LEN-1:0] m0_wsel,
    input  logic [`CACHE_D_WRITE_LEN-1:0] m1_wsel,
    input  logic [31:0]                   m0_addr,
    input  logic [31:0]                   m1_addr,
    input  logic [31:0]                   m0_wdata,
    input  logic [31:0]                   m1_wdata,
    output logic                          m0_gnt,
    output logic                          m1_gnt,
    output logic                          m0_rvalid,
    output logic                          m1_rvalid,
    output logic [31:0]                   rdata,
    output logic                          bus_write_en,
    output logic [`CACHE_D_WRITE_LEN-1:0] bus_write,
    output logic [31:0]                   bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic [31:0]                   bus_rdata,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t                          state;
    logic [2:0]                      cnt;
    logic                            owner;
    logic                            pick_m1;
    logic                            any_req;
    logic                            grant_ok;
    logic                            sel_we;
    logic [`CACHE_D_WRITE_LEN-1:0]   sel_wsel;
    logic [31:0]                     sel_addr;
    logic [31:0]                     sel_wdata;
    logic [`CACHE_D_WRITE_LEN-1:0]   wsel_q;
    logic [31:0]                     addr_q;
    logic [31:0]                     wdata_q;

`ifdef RISCV_DMEM_ARB_RR_EN
    logic                            last_owner;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        pick_m1 = m1_req && (!m0_req || !last_owner);
    end
`else
    always_comb begin
        pick_m1 = m1_req && !m0_req;
    end
`endif

    always_comb begin
        any_req   = m0_req || m1_req;
        grant_ok  = (state == IDLE) && !rst;
        m0_gnt    = grant_ok && m0_req && !pick_m1;
        m1_gnt    = grant_ok && pick_m1;
        sel_we    = pick_m1 ? m1_we    : m0_we;
        sel_wsel  = pick_m1 ? m1_wsel  : m0_wsel;
        sel_addr  = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            owner   <= 1'b1;
            wsel_q  <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
`ifdef RISCV_DMEM_ARB_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= pick_m1;
                        wsel_q  <= sel_wsel;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt     <= 3'(READ_LAT - 1);
                        state   <= sel_we ? WR : RD;
`ifdef RISCV_DMEM_ARB_RR_EN
                        last_owner <= pick_m1;
`endif
                    end
                end
                WR: state <= IDLE;
                RD: begin
                    // Bridge data is taken on the final cycle of the read window.
                    if (cnt == 3'd0) begin
                        rdata <= bus_rdata;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE) && !rst;
        bus_write_en = (state == WR) && !rst;
        m0_rvalid    = (state == RESP) && !owner && !rst;
        m1_rvalid    = (state == RESP) && owner && !rst;
        bus_write    = wsel_q;
        bus_addr     = addr_q;
        bus_wdata    = wdata_q;
    end

endmodule

// File: doc/riscv_dmem_arbiter.md
RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, data-port read latency in cycles (legal 1..4).
REQ-002 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have m0_req/m1_req  input  1 each  access request (m0 = CPU load/store, m1 = secondary master).
REQ-005 SHALL have m0_we/m1_we  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have m0_wsel/m1_wsel  input  `CACHE_D_WRITE_LEN each  write size code (`CACHE_D_WRITE_SW/SH/SB).
REQ-007 SHALL have m0_addr/m1_addr, m0_wdata/m1_wdata  input  32 each  address, store data.
REQ-008 SHALL have m0_gnt/m1_gnt  output  1 each  request accepted this cycle.
REQ-009 SHALL have m0_rvalid/m1_rvalid  output  1 each  read data valid pulse.
REQ-010 SHALL have rdata  output  32  read data shared by both masters, qualified by rvalid.
REQ-011 SHALL have bus_write_en  output  1; bus_write  output  `CACHE_D_WRITE_LEN; bus_addr, bus_wdata  output  32; bus_rdata  input  32: port to the IO bridge.
REQ-012 SHALL have busy  output  1  high when state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WR, RD, RESP.
REQ-014 In IDLE with any req high, SHALL select one winner, assert its gnt combinationally that cycle, latch its we/wsel/addr/wdata and owner id at the edge.
REQ-015 IDLE SHALL go to WR if latched we=1, else RD; with no req, remain IDLE, both gnt low.
REQ-016 gnt SHALL be asserted only in IDLE, at most one per cycle; req SHALL be ignored in WR, RD, RESP.
REQ-017 Requester SHALL hold req and fields stable until gnt sampled high, and SHALL drop or present a new request afterwards.
REQ-018 WR SHALL last exactly one cycle with bus_write_en=1 and bus_write/bus_addr/bus_wdata from latches, then go to IDLE (write = 2 cycles req-to-idle).
REQ-019 RD SHALL drive bus_addr from latch with bus_write_en=0 for READ_LAT cycles (down-counter), capture bus_rdata into rdata at the last RD edge, then go to RESP.
REQ-020 RESP SHALL assert owner's rvalid for exactly one cycle, then go to IDLE; read = READ_LAT+2 cycles from gnt cycle to rvalid cycle inclusive.
REQ-021 rdata SHALL hold its value until the next read capture.
REQ-022 Outside WR, bus_write_en SHALL be 0; bus_addr/bus_write/bus_wdata SHALL hold last latched values.
REQ-023 Single requester SHALL always win regardless of arbitration mode.
REQ-024 Back-to-back: a request held through WR/RD/RESP SHALL be eligible in the next IDLE cycle (no dead cycle beyond IDLE).

Reset
REQ-025 On rst high at an edge: state IDLE, counter 0, owner/last-owner = m1, latches 0, rdata 0.
REQ-026 While rst high: gnt, rvalid, bus_write_en, busy all 0.
REQ-027 Reset mid-RD or mid-WR SHALL abort the transaction with no rvalid and no further bus write.

Configuration
REQ-028 Macro RISCV_DMEM_ARB_RR_EN defined: on simultaneous requests, winner SHALL be the master not granted last (round-robin; after reset m0 wins first tie).
REQ-029 Macro undefined: on simultaneous requests m0 SHALL always win (fixed priority); last-owner register may be omitted.

Verification
REQ-030 Reset, m0 read addr 0x10, READ_LAT=1, bus_rdata=0xDEADBEEF -> m0_gnt cycle 0, RD cycle 1, m0_rvalid cycle 2 with rdata=0xDEADBEEF.
REQ-031 m1 write SB addr 0xFFFFFC04 data 0xA5 -> m1_gnt cycle 0, bus_write_en=1 cycle 1 only with bus_addr=0xFFFFFC04, bus_wdata=0xA5, bus_write=SB.
REQ-032 Both req held continuously, reads -> RR_EN: grants m0,m1,m0,m1; not defined: m0 every transaction, m1 never.
REQ-033 READ_LAT=3, m0 read -> busy high 4 cycles, m0_rvalid exactly cycle 4 after gnt, m1_rvalid never.
REQ-034 rst asserted during RD of m0 read -> next cycle IDLE, busy 0, no m0_rvalid; subsequent m1 read completes normally.
